serial_borrow_subtractor: RTL and testbench
===========================================

Name: serial_borrow_subtractor

Overview:
- Bit-serial subtractor that computes Dout = A - B - Bin, one bit per clock, LSB first, using a single full-subtractor cell.
- It is the subtraction counterpart of the combinational ripple-carry adder datapath.
- It trades area for latency: WIDTH cycles per operation, with a start/busy/done handshake.
- It is intended for area-constrained datapaths that already issue operand pairs from a small controller.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the start edge.
- B  input  WIDTH  subtrahend; sampled on the start edge.
- Bin  input  1  borrow-in; sampled on the start edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Dout/Bout become valid.
- Dout  output  WIDTH  difference.
- Bout  output  1  borrow-out (1 when A < B + Bin, unsigned).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - busy=0, done=0, Dout=0, Bout=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Reset mid-operation aborts the operation, with no done pulse.
- State machine IDLE, RUN:
  - IDLE & start=1 at edge E0:
    - latch A into a_sh, B into b_sh, Bin into the borrow flop.
    - clear the bit counter.
    - busy<=1, state<=RUN.
  - IDLE & start=0: hold all state; done<=0.
  - RUN, each edge:
    - d = a_sh[0]^b_sh[0]^borrow
    - borrow <= (~a_sh[0]&b_sh[0]) | (~a_sh[0]&borrow) | (b_sh[0]&borrow)
    - a_sh and b_sh shift right by 1.
    - d shifts into the MSB of the internal result register (right shift).
    - counter += 1.
  - RUN edge where counter==WIDTH-1 (the WIDTH-th RUN edge):
    - Dout <= completed result, including that edge's bit.
    - Bout <= that edge's borrow_next.
    - done<=1, busy<=0, state<=IDLE.
- Latency:
  - start sampled at E0 → done high after edge E0+WIDTH, for exactly one cycle.
  - Throughput is one operation per WIDTH+1 cycles, because start is re-sampled in the cycle done is high.
- Result hold:
  - Dout and Bout change only on completion edges or reset.
  - They hold stable between operations, including throughout the following RUN.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - start in the same cycle as done=1: accepted; the next done arrives WIDTH edges later.
  - A/B/Bin changes during RUN: no effect.
  - A==B, Bin=0: Dout=0, Bout=0.
  - Wrap-around: results are modulo 2^WIDTH; the underflow indication is Bout.
- Counter width is clog2(WIDTH). The counter never exceeds WIDTH-1.

Optional Feature:
- Macro SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0, updated only on completion edges together with Dout.
  - ovf=1 when the two's-complement A - B - Bin is not representable in WIDTH bits, i.e. sign(A)!=sign(B) and sign(Dout)!=sign(A).
  - Sign bits are taken from A and B as latched at start.
- Undefined:
  - No ovf port and no extra flops.
  - All other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
  - default width constant SERIAL_WIDTH_DEF=4.
  - counter-width function clog2.
- One sub-module, full_subtractor:
  - combinational single-bit cell; inputs a, b, bin; outputs d, bout.
  - equations as above.
  - instantiated once in the RUN datapath; the top-level module owns all flops.

Test Plan:
- 9 - 3, Bin=0, WIDTH=4:
  - busy=1 for 4 cycles.
  - done pulses 4 edges after start.
  - Dout=4'h6, Bout=0.
- 3 - 9, Bin=0:
  - Dout=4'hA, Bout=1.
  - Previous result (6, 0) holds until the completion edge.
- 0 - 0, Bin=1:
  - Dout=4'hF, Bout=1.
  - Then 15 - 15, Bin=0, started in the done cycle: Dout=0, Bout=0, done exactly 4 edges later.
- Start pulses at RUN cycles 1 and 2 with different operands:
  - ignored; only the first operation's result is produced, with one done pulse.
- Assert rst during RUN cycle 2:
  - busy=0, done=0, Dout=0, Bout=0 immediately.
  - No done pulse afterwards.
  - Next start of 5 - 2 gives Dout=3, Bout=0.
- With SERIAL_SUB_SIGNED_OVF_EN:
  - 4'h8 - 4'h1: Dout=4'h7, ovf=1, Bout=0.
  - 4'h7 - 4'hF: Dout=4'h8, ovf=1, Bout=1.
  - 4'h2 - 4'h3: Dout=4'hF, ovf=0, Bout=1.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: state encoding,
// default operand width and a constant-evaluable ceil(log2) helper.
package serial_arith_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } serial_state_t;

  localparam int SERIAL_WIDTH_DEF = 4;

  // Returns at least 1 so a counter declared from it is never zero-width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, bout = borrow to next bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor, Dout = A - B - Bin, LSB first, one bit per clock.
// Optional signed-overflow flag output enabled by SERIAL_SUB_SIGNED_OVF_EN.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | waiting for start; Dout/Bout hold the last completed result
//   ST_RUN  | one operand bit per edge through the full subtractor cell
module serial_borrow_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Dout,
  output logic             Bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  serial_state_t    state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             borrow_q, borrow_d;
  // Only WIDTH-1 bits are stored; the final bit comes straight from the cell.
  logic [WIDTH-2:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] dout_d;
  logic             bout_d;
  logic [WIDTH-1:0] res_full;
  logic             fs_d, fs_bout;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_sgn_q, a_sgn_d;
  logic b_sgn_q, b_sgn_d;
  logic ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign res_full = {fs_d, res_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    busy_d   = busy;
    done_d   = 1'b0;
    dout_d   = Dout;
    bout_d   = Bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    a_sgn_d  = a_sgn_q;
    b_sgn_d  = b_sgn_q;
    ovf_d    = ovf;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          borrow_d = Bin;
          res_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          a_sgn_d  = A[WIDTH-1];
          b_sgn_d  = B[WIDTH-1];
`endif
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = fs_bout;
        res_d    = res_full[WIDTH-1:1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          dout_d  = res_full;
          bout_d  = fs_bout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_d   = (a_sgn_q != b_sgn_q) && (res_full[WIDTH-1] != a_sgn_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Dout     <= '0;
      Bout     <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_sgn_q  <= 1'b0;
      b_sgn_q  <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      borrow_q <= borrow_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      Dout     <= dout_d;
      Bout     <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_sgn_q  <= a_sgn_d;
      b_sgn_q  <= b_sgn_d;
      ovf      <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor; checks ovf when
// SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_borrow_subtractor;

  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy, done, Bout;
  logic [W-1:0] Dout;
  logic         ovf_w;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Dout  (Dout),
    .Bout  (Bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf_w)
`endif
  );

`ifndef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int dout;
    int bout;
    int ovf;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_due = -1;
  int   checks = 0;
  int   errors = 0;
  bit   checking = 0;
  int   cur_dout = 0;
  int   cur_bout = 0;
  int   cur_ovf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input int a, input int b, input int bin, input int due);
    exp_t e;
    int diff, sa, sb, sdiff;
    diff   = a - b - bin;
    e.due  = due;
    e.dout = ((diff % MOD) + MOD) % MOD;
    e.bout = (diff < 0) ? 1 : 0;
    sa     = (a >= HALF) ? a - MOD : a;
    sb     = (b >= HALF) ? b - MOD : b;
    sdiff  = sa - sb - bin;
    e.ovf  = (sdiff < -HALF || sdiff > HALF - 1) ? 1 : 0;
    return e;
  endfunction

  task automatic do_start(input int a, input int b, input int bin);
    @(negedge clk);
    start = 1'b1;
    A     = W'(a);
    B     = W'(b);
    Bin   = bin[0];
    @(posedge clk);
    #1;
    if (cyc > last_due) begin
      q.push_back(model(a, b, bin, cyc + W));
      last_due = cyc + W;
    end
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Bin   = 1'($urandom);
  endtask

  always @(negedge clk) begin
    if (checking && !rst) begin
      exp_t e;
      chk("busy", int'(busy), (q.size() > 0 && cyc < q[0].due) ? 1 : 0);
      if (done) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          cur_dout = e.dout;
          cur_bout = e.bout;
          cur_ovf  = e.ovf;
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        chk("missing_done", 0, 1);
        void'(q.pop_front());
      end
      chk("Dout", int'(Dout), cur_dout);
      chk("Bout", int'(Bout), cur_bout);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      chk("ovf", int'(ovf_w), cur_ovf);
`endif
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_Dout", int'(Dout), 0);
    chk("rst_Bout", int'(Bout), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    checking = 1;

    do_start(9, 3, 0);
    repeat (W + 1) @(posedge clk);
    do_start(3, 9, 0);
    repeat (W + 1) @(posedge clk);
    do_start(0, 0, 1);
    repeat (W) @(posedge clk);
    do_start(15, 15, 0);
    repeat (W) @(posedge clk);
    do_start(6, 6, 0);

    // Starts during RUN cycles 1 and 2 must be dropped.
    repeat (W + 1) @(posedge clk);
    do_start(12, 5, 1);
    do_start(1, 14, 0);
    do_start(7, 7, 1);
    repeat (W + 1) @(posedge clk);

    // Abort mid-operation with reset.
    do_start(10, 4, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    q.delete();
    cur_dout = 0;
    cur_bout = 0;
    cur_ovf  = 0;
    last_due = -1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_Dout", int'(Dout), 0);
    chk("abort_Bout", int'(Bout), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (W + 2) @(posedge clk);
    do_start(5, 2, 0);
    repeat (W + 1) @(posedge clk);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    do_start(8, 1, 0);
    repeat (W + 1) @(posedge clk);
    do_start(7, 15, 0);
    repeat (W + 1) @(posedge clk);
    do_start(2, 3, 0);
    repeat (W + 1) @(posedge clk);
`endif

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, W + 1)) @(posedge clk);
      do_start(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
               int'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("drain_pending", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
